fu_seq_arbiter: RTL and testbench

Sequencer and two-requester round-robin arbiter for a shared single-cycle-registered functional unit such as `leftshift` (operands `a`, `b`, op select `ctrl`, result `out` qualified by `out_en`). It accepts operation requests from two clients and drives the unit's operand and control inputs stable for the whole operation. It waits for `out_en`, returns the result to the winning client, and parks the unit on an idle control code between operations. A watchdog bounds every wait so that a hung or unselected unit cannot stall a client.

---
 rtl/fu_seq_pkg.sv | 34 +++
 rtl/fu_seq_arbiter_rr_arb2.sv | 34 +++
 rtl/fu_seq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fu_seq_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_seq_pkg.sv
// fu_seq_pkg: shared types and constants for the functional-unit sequencer.
//   state_t        - sequencer FSM states
//   owner_t        - requester ID (0 = r0, 1 = r1)
//   IDLE_CTRL_DEF  - control code the unit never answers (parks the unit)
//   OP_*           - operation codes understood by the shift unit
package fu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  typedef logic owner_t;

  localparam logic [4:0] IDLE_CTRL_DEF = 5'h1F;

  localparam logic [4:0] OP_SHL = 5'd0;
  localparam logic [4:0] OP_SHR = 5'd1;
  localparam logic [4:0] OP_ROL = 5'd2;
  localparam logic [4:0] OP_SRA = 5'd3;

  // Round-robin rule: the requester that was not served last has priority.
  function automatic owner_t rr_pick(input logic [1:0] req, input owner_t last);
    owner_t pick;
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else if (req[1]) pick = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/fu_seq_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst   - clock, synchronous active-high reset
//   req[1:0]   - request vector {r1, r0}
//   gnt_valid  - some request is present (combinational)
//   gnt_id     - winning requester (combinational)
//   upd        - handshake strobe; records upd_id as the last winner
//   upd_id     - requester that completed the handshake
// After reset 'last' points at requester 1 so requester 0 wins the first tie.
module rr_arb2
  import fu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_id,
  input  logic       upd,
  input  logic       upd_id
);

  owner_t last_q, last_d;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = rr_pick(req, last_q);
    last_d    = upd ? upd_id : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/fu_seq_arbiter.sv
// fu_seq_arbiter: sequences operations from two clients onto one shared
// registered functional unit (e.g. a shifter) with round-robin arbitration.
//   clk, rst                 - clock, synchronous active-high reset
//   rN_valid / rN_ready      - request handshake (ready only in IDLE)
//   rN_a, rN_b, rN_ctrl      - request operands, sampled at the handshake
//   rN_rsp_valid/data/err    - one-cycle response pulse, err = watchdog expiry
//   fu_a, fu_b, fu_ctrl      - registered unit inputs
//   fu_out_en, fu_out        - unit result and its qualifier
// Flow: IDLE -> ISSUE -> WAIT -> RESP -> DRAIN -> IDLE. The watchdog bounds
// both WAIT (no answer) and DRAIN (answer that never goes away).
module fu_seq_arbiter
  import fu_seq_pkg::*;
#(
  parameter int             DW        = 32,
  parameter int             SW        = 5,
  parameter int             CW        = 5,
  parameter int             TIMEOUT   = 16,
  parameter logic [CW-1:0]  IDLE_CTRL = CW'(IDLE_CTRL_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [DW-1:0] r0_a,
  input  logic [SW-1:0] r0_b,
  input  logic [CW-1:0] r0_ctrl,
  output logic          r0_rsp_valid,
  output logic [DW-1:0] r0_rsp_data,
  output logic          r0_rsp_err,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [DW-1:0] r1_a,
  input  logic [SW-1:0] r1_b,
  input  logic [CW-1:0] r1_ctrl,
  output logic          r1_rsp_valid,
  output logic [DW-1:0] r1_rsp_data,
  output logic          r1_rsp_err,
  output logic [DW-1:0] fu_a,
  output logic [SW-1:0] fu_b,
  output logic [CW-1:0] fu_ctrl,
  input  logic          fu_out_en,
  input  logic [DW-1:0] fu_out
);

  localparam int              CNTW     = $clog2(TIMEOUT) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [DW-1:0]          fu_a_q, fu_a_d;
  logic [SW-1:0]          fu_b_q, fu_b_d;
  logic [CW-1:0]          fu_ctrl_q, fu_ctrl_d;
  logic [CNTW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [1:0][DW-1:0]     rsp_data_q, rsp_data_d;

  logic [1:0]             req_valid;
  logic [1:0]             ready;
  logic                   gnt_valid, gnt_id, arb_upd;

  assign req_valid = {r1_valid, r0_valid};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .upd       (arb_upd),
    .upd_id    (gnt_id)
  );

  // Watchdog counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_ctrl_d   = fu_ctrl_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;           // response is a single-cycle pulse
    rsp_err_d   = '0;
    rsp_data_d  = rsp_data_q;
    ready       = '0;
    arb_upd     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          ready[gnt_id] = 1'b1;
          arb_upd       = 1'b1;
          owner_d       = gnt_id;
          fu_a_d        = gnt_id ? r1_a    : r0_a;
          fu_b_d        = gnt_id ? r1_b    : r0_b;
          fu_ctrl_d     = gnt_id ? r1_ctrl : r0_ctrl;
          state_d       = ST_ISSUE;
        end
      end

      // The unit sees the new inputs this cycle; any out_en now is stale.
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (fu_out_en) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d[owner_q]  = fu_out;
          fu_ctrl_d            = IDLE_CTRL;
          state_d              = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d[owner_q]   = 1'b1;
          rsp_data_d[owner_q]  = '0;
          fu_ctrl_d            = IDLE_CTRL;
          state_d              = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // Unit is parked on IDLE_CTRL already; restart the watchdog for DRAIN.
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end

      // Wait for the unit's result strobe to drop so a late answer from this
      // operation cannot be mistaken for the next one's.
      ST_DRAIN: begin
        if (!fu_out_en || cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                                 cnt_d   = cnt_inc;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_ctrl_q   <= IDLE_CTRL;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      fu_ctrl_q   <= fu_ctrl_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign r0_ready     = ready[0];
  assign r1_ready     = ready[1];
  assign r0_rsp_valid = rsp_valid_q[0];
  assign r1_rsp_valid = rsp_valid_q[1];
  assign r0_rsp_err   = rsp_err_q[0];
  assign r1_rsp_err   = rsp_err_q[1];
  assign r0_rsp_data  = rsp_data_q[0];
  assign r1_rsp_data  = rsp_data_q[1];
  assign fu_a         = fu_a_q;
  assign fu_b         = fu_b_q;
  assign fu_ctrl      = fu_ctrl_q;

endmodule

// File: tb/tb_fu_seq_arbiter.sv
// Testbench for fu_seq_arbiter: directed request sequences against a stub
// shift unit (real / stuck-low / stuck-high), a timeline model of the
// sequencer's externally visible behaviour, and literal spot checks.
module tb_fu_seq_arbiter;
  import fu_seq_pkg::*;

  localparam int          DW   = 32;
  localparam int          SW   = 5;
  localparam int          CW   = 5;
  localparam int          TO   = 16;
  localparam logic [4:0]  IC   = 5'h1F;
  localparam logic [31:0] STUB = 32'hCAFE_0001;
  localparam int          TIE_D [4] = '{16, 20, 15, 48};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [DW-1:0] r0_a = '0, r1_a = '0;
  logic [SW-1:0] r0_b = '0, r1_b = '0;
  logic [CW-1:0] r0_ctrl = '0, r1_ctrl = '0;
  logic          r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic [DW-1:0] fu_a;
  logic [SW-1:0] fu_b;
  logic [CW-1:0] fu_ctrl;
  logic          fu_out_en;
  logic [DW-1:0] fu_out;

  fu_seq_arbiter #(.DW(DW), .SW(SW), .CW(CW), .TIMEOUT(TO), .IDLE_CTRL(IC)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .fu_a(fu_a), .fu_b(fu_b), .fu_ctrl(fu_ctrl), .fu_out_en(fu_out_en), .fu_out(fu_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Stub unit: 0 = real registered shifter, 1 = never answers, 2 = always answers.
  int fu_mode = 0;
  always @(posedge clk) begin
    if (rst) begin
      fu_out_en <= 1'b0;
      fu_out    <= '0;
    end else if (fu_mode == 1) begin
      fu_out_en <= 1'b0;
      fu_out    <= '0;
    end else if (fu_mode == 2) begin
      fu_out_en <= 1'b1;
      fu_out    <= STUB;
    end else begin
      fu_out_en <= (fu_ctrl <= OP_SRA);
      case (fu_ctrl)
        OP_SHL:  fu_out <= fu_a << fu_b;
        OP_SHR:  fu_out <= fu_a >> fu_b;
        OP_ROL:  fu_out <= (fu_a << fu_b) | (fu_a >> (6'd32 - {1'b0, fu_b}));
        default: fu_out <= $unsigned($signed(fu_a) >>> fu_b);
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [31:0] a, input logic [4:0] b,
                                           input logic [4:0] c);
    logic [63:0] p;
    p = 64'(a) * (64'd1 << b);
    if (c == OP_SHL) return p[31:0];
    if (c == OP_SHR) return a / (32'd1 << b);
    return 32'h0;
  endfunction

  // ---------------- timeline model ----------------
  int          m_free_at = 0;
  int          m_last = 1;
  logic [31:0] m_fu_a = '0, m_upd_a = '0;
  logic [4:0]  m_fu_b = '0, m_upd_b = '0, m_op_ctrl = '0;
  int          m_upd_cyc = -1, m_op_lo = -1, m_op_hi = -2;
  int          e_act [2] = '{0, 0};
  int          e_cyc [2] = '{0, 0};
  logic [31:0] e_dat [2] = '{0, 0};
  logic        e_err [2] = '{0, 0};
  int          acc_cnt [2] = '{0, 0};

  // observed DUT events for literal checks
  int          hs_cyc [64], hs_id [64], rsp_cyc [64], rsp_id [64];
  logic [31:0] rsp_dat [64];
  logic        rsp_er [64];
  int          n_hs = 0, n_rsp = 0;

  initial forever begin
    logic [1:0]  v, er, dv, derr;
    logic [31:0] dd [2];
    logic [31:0] a, d;
    logic [4:0]  b, c;
    int          gid, rc, fr;
    logic        e, ev;
    @(negedge clk);
    dv   = {r1_rsp_valid, r0_rsp_valid};
    derr = {r1_rsp_err, r0_rsp_err};
    dd[0] = r0_rsp_data;
    dd[1] = r1_rsp_data;
    for (int i = 0; i < 2; i++) begin
      if (dv[i] && n_rsp < 64) begin
        rsp_cyc[n_rsp] = cyc; rsp_id[n_rsp] = i;
        rsp_dat[n_rsp] = dd[i]; rsp_er[n_rsp] = derr[i];
        n_rsp++;
        $display("cyc %0d rsp r%0d data=%0h err=%0d", cyc, i, dd[i], derr[i]);
      end
    end
    if (rst) begin
      m_free_at = cyc + 1; m_last = 1;
      m_fu_a = '0; m_fu_b = '0; m_upd_cyc = -1; m_op_lo = -1; m_op_hi = -2;
      e_act[0] = 0; e_act[1] = 0;
    end else begin
      if (cyc == m_upd_cyc) begin m_fu_a = m_upd_a; m_fu_b = m_upd_b; end
      v  = {r1_valid, r0_valid};
      er = 2'b00;
      gid = 0;
      if (cyc >= m_free_at && v != 2'b00) begin
        gid = (v == 2'b11) ? (1 - m_last) : (v[1] ? 1 : 0);
        er[gid] = 1'b1;
      end
      chk("ready0", 32'(r0_ready), 32'(er[0]));
      chk("ready1", 32'(r1_ready), 32'(er[1]));
      for (int i = 0; i < 2; i++) begin
        ev = (e_act[i] != 0) && (e_cyc[i] == cyc);
        chk(i == 0 ? "rsp_valid0" : "rsp_valid1", 32'(dv[i]), 32'(ev));
        if (ev) begin
          chk(i == 0 ? "rsp_data0" : "rsp_data1", dd[i], e_dat[i]);
          chk(i == 0 ? "rsp_err0" : "rsp_err1", 32'(derr[i]), 32'(e_err[i]));
          e_act[i] = 0;
        end
      end
      chk("fu_a", fu_a, m_fu_a);
      chk("fu_b", 32'(fu_b), 32'(m_fu_b));
      chk("fu_ctrl", 32'(fu_ctrl), (cyc >= m_op_lo && cyc <= m_op_hi) ? 32'(m_op_ctrl) : 32'(IC));
      if ((r0_ready && r0_valid) || (r1_ready && r1_valid)) begin
        if (n_hs < 64) begin
          hs_cyc[n_hs] = cyc; hs_id[n_hs] = r1_ready ? 1 : 0; n_hs++;
        end
        $display("cyc %0d grant r%0d", cyc, r1_ready ? 1 : 0);
      end
      if (er != 2'b00) begin
        a = gid ? r1_a : r0_a;
        b = gid ? r1_b : r0_b;
        c = gid ? r1_ctrl : r0_ctrl;
        m_last = gid;
        acc_cnt[gid]++;
        m_upd_cyc = cyc + 1; m_upd_a = a; m_upd_b = b;
        m_op_lo = cyc + 1; m_op_ctrl = c;
        if (fu_mode == 1) begin
          rc = cyc + 2 + TO; d = 32'h0; e = 1'b1; fr = rc + 2;
        end else if (fu_mode == 2) begin
          rc = cyc + 3; d = STUB; e = 1'b0; fr = cyc + 4 + TO;
        end else begin
          rc = cyc + 3; d = model_op(a, b, c); e = 1'b0; fr = cyc + 5;
        end
        m_op_hi = rc - 1;
        m_free_at = fr;
        e_act[gid] = 1; e_cyc[gid] = rc; e_dat[gid] = d; e_err[gid] = e;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic request(input int id, input logic [31:0] a, input logic [4:0] b,
                         input logic [4:0] c);
    int start, n;
    start = acc_cnt[id];
    if (id == 0) begin r0_a = a; r0_b = b; r0_ctrl = c; r0_valid = 1'b1; end
    else         begin r1_a = a; r1_b = b; r1_ctrl = c; r1_valid = 1'b1; end
    n = 0;
    while (acc_cnt[id] == start && n < 300) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 32'(acc_cnt[id] != start), 32'd1);
    if (id == 0) r0_valid = 1'b0;
    else         r1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < m_free_at && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_wait", 32'(cyc >= m_free_at), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s, hb, rb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    chk("rst_fu_ctrl", 32'(fu_ctrl), 32'h1F);
    chk("rst_fu_a", fu_a, 32'h0);
    chk("rst_rsp_data0", r0_rsp_data, 32'h0);
    chk("rst_rsp_data1", r1_rsp_data, 32'h0);
    chk("rst_rsp_valid", 32'({r1_rsp_valid, r0_rsp_valid}), 32'h0);

    // tie from reset: r0, r1, r0, r1 at 5-cycle spacing
    hb = n_hs; rb = n_rsp; s = cyc;
    fork
      begin request(0, 32'd1, 5'd4, OP_SHL); request(0, 32'hF0, 5'd4, OP_SHR); end
      begin request(1, 32'd5, 5'd2, OP_SHL); request(1, 32'd6, 5'd3, OP_SHL); end
    join
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      chk("tie_hs_cyc", 32'(hs_cyc[hb+k]), 32'(s + 5*k));
      chk("tie_hs_id", 32'(hs_id[hb+k]), 32'(k % 2));
      chk("tie_rsp_cyc", 32'(rsp_cyc[rb+k]), 32'(s + 5*k + 3));
      chk("tie_rsp_data", rsp_dat[rb+k], 32'(TIE_D[k]));
    end

    // single op: 59 << 3
    s = cyc;
    request(0, 32'd59, 5'd3, OP_SHL);
    chk("single_fu_a", fu_a, 32'd59);
    repeat (2) @(posedge clk);
    #1;
    chk("single_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    chk("single_rsp_data", r0_rsp_data, 32'd472);
    chk("single_rsp_err", 32'(r0_rsp_err), 32'd0);
    chk("single_fu_ctrl", 32'(fu_ctrl), 32'h1F);
    chk("single_cyc", 32'(cyc), 32'(s + 3));
    wait_idle();

    // operand stability: r1_a changes while r1 waits behind r0
    rb = n_rsp; s = cyc;
    fork
      request(0, 32'd100, 5'd2, OP_SHL);
      begin
        @(posedge clk); #1;
        fork
          request(1, 32'd7, 5'd1, OP_SHL);
          begin repeat (2) @(posedge clk); #1; r1_a = 32'd9; end
        join
      end
    join
    wait_idle();
    chk("stab_r0_data", rsp_dat[rb], 32'd400);
    chk("stab_r1_id", 32'(rsp_id[rb+1]), 32'd1);
    chk("stab_r1_cyc", 32'(rsp_cyc[rb+1]), 32'(s + 8));
    chk("stab_r1_data", rsp_dat[rb+1], 32'd18);

    // timeout: unit never answers
    fu_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rb = n_rsp; s = cyc;
    request(0, 32'd11, 5'd1, OP_SHL);
    wait_idle();
    chk("to_rsp_cyc", 32'(rsp_cyc[rb]), 32'(s + 2 + TO));
    chk("to_rsp_err", 32'(rsp_er[rb]), 32'd1);
    chk("to_rsp_data", rsp_dat[rb], 32'd0);
    fu_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // stuck out_en: DRAIN lasts TIMEOUT cycles before the next grant
    fu_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    hb = n_hs; rb = n_rsp; s = cyc;
    fork
      request(1, 32'd2, 5'd2, OP_SHL);
      begin @(posedge clk); #1; request(0, 32'd3, 5'd3, OP_SHL); end
    join
    wait_idle();
    chk("stuck_rsp_cyc", 32'(rsp_cyc[rb]), 32'(s + 3));
    chk("stuck_rsp_data", rsp_dat[rb], STUB);
    chk("stuck_next_hs", 32'(hs_cyc[hb+1]), 32'(s + 4 + TO));
    chk("stuck_next_id", 32'(hs_id[hb+1]), 32'd0);
    fu_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset during WAIT
    rb = n_rsp; s = cyc;
    request(0, 32'd1, 5'd1, OP_SHL);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_fu_ctrl", 32'(fu_ctrl), 32'h1F);
    chk("mid_rst_fu_a", fu_a, 32'h0);
    chk("mid_rst_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    request(0, 32'd21, 5'd2, OP_SHL);
    wait_idle();
    chk("mid_rst_n_rsp", 32'(n_rsp - rb), 32'd1);
    chk("mid_rst_rsp_cyc", 32'(rsp_cyc[rb]), 32'(s + 6));
    chk("mid_rst_rsp_data", rsp_dat[rb], 32'd84);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
